// File: rtl/apb_pkg.sv
// Shared APB constants, FSM state encoding and response record used by the
// master, its bus interface and the downstream slave.
package apb_pkg;

    localparam int D_WIDTH   = 32;
    localparam int MEM_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [D_WIDTH-1:0] rdata;
        logic               err;
        logic               timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// Command, response and APB signal bundle between a command source, the APB
// master and the APB slave.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int D_WIDTH = apb_pkg::D_WIDTH
);

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_write;
    logic [D_WIDTH-1:0] cmd_addr;
    logic [D_WIDTH-1:0] cmd_wdata;
    logic [2:0]         cmd_prot;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [D_WIDTH-1:0] rsp_rdata;
    logic               rsp_err;
    logic               rsp_timeout;

    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [D_WIDTH-1:0] paddr;
    logic [D_WIDTH-1:0] pwdata;
    logic [2:0]         pprot;
    logic               pready;
    logic               pslverr;
    logic [D_WIDTH-1:0] prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata, pprot,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pprot,
        output pready, pslverr, prdata
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter; flags the cycle in which the slave is
// still stalling after TIMEOUT wait states. TIMEOUT = 0 disables it.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at LIMIT so a long stall can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (cnt_q == LIMIT);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: one valid/ready command becomes one
// SETUP/ACCESS transfer and one held response, with a wait-state timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int D_WIDTH = apb_pkg::D_WIDTH,
    parameter int TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          preset,
    apb_master_if.master  bus
);

    apb_state_e         state_q,     state_d;
    logic [D_WIDTH-1:0] paddr_q,     paddr_d;
    logic [D_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic               pwrite_q,    pwrite_d;
    logic [2:0]         pprot_q,     pprot_d;
    logic               rsp_valid_q, rsp_valid_d;
    apb_rsp_t           rsp_q,       rsp_d;
    logic               alive_q,     alive_d;

    logic cmd_ready;
    logic accept;
    logic wait_en;
    logic expired;

    // alive_q keeps cmd_ready low in the cycle right after a reset edge.
    assign cmd_ready = alive_q && (state_q == IDLE) && (!rsp_valid_q || bus.rsp_ready);
    assign accept    = bus.cmd_valid && cmd_ready;
    assign wait_en   = (state_q == ACCESS) && !bus.pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (pclk),
        .rst     (preset),
        .clear   (accept),
        .enable  (wait_en),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        pprot_d     = pprot_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        alive_d     = 1'b1;

        if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SETUP;
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_wdata;
                    pwrite_d = bus.cmd_write;
                    pprot_d  = bus.cmd_prot;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // pready is tested first so it wins over a coincident timeout.
                if (bus.pready) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_d.rdata   = (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
                    rsp_d.err     = bus.pslverr;
                    rsp_d.timeout = 1'b0;
                end else if (expired) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            pprot_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            pprot_q     <= pprot_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            alive_q     <= alive_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.psel        = (state_q != IDLE);
    assign bus.penable     = (state_q == ACCESS);
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pprot       = pprot_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_q.rdata;
    assign bus.rsp_err     = rsp_q.err;
    assign bus.rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a small memory-backed APB slave with a
// programmable wait count, a vector table and hand-written corner sequences.
module tb_apb_master;
    import apb_pkg::*;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  prot;
        int          waits;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_lat;
    } vec_t;

    localparam int NVEC  = 10;
    localparam int NEVER = 255;

    logic pclk = 1'b0;
    logic preset;
    always #5 pclk = ~pclk;

    apb_master_if #(.D_WIDTH(D_WIDTH)) bus();

    apb_master #(
        .D_WIDTH (D_WIDTH),
        .TIMEOUT (16)
    ) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    // APB slave model: pready after cur_wait low ACCESS cycles, error beyond MEM_DEPTH.
    logic [31:0] mem [MEM_DEPTH];
    int          cur_wait;
    int          acc_cnt;
    logic        mem_clr;
    logic        in_access;
    logic        addr_ok;

    assign in_access = bus.psel && bus.penable;
    assign addr_ok   = (bus.paddr < 32'(MEM_DEPTH));

    always_comb begin
        bus.pready  = in_access && (acc_cnt >= cur_wait);
        bus.pslverr = in_access && bus.pready && !addr_ok;
        bus.prdata  = 32'hBAD0_BAD0;
        if (bus.pwrite)  bus.prdata = 32'hFEED_F00D;
        else if (addr_ok) bus.prdata = mem[bus.paddr[3:0]];
    end

    always @(posedge pclk) begin
        if (in_access && !bus.pready) acc_cnt <= acc_cnt + 1;
        else                          acc_cnt <= 0;
        if (mem_clr) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 32'h0;
        end else if (in_access && bus.pready && bus.pwrite && addr_ok) begin
            mem[bus.paddr[3:0]] <= bus.pwdata;
        end
    end

    int   checks = 0;
    int   errors = 0;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_psel"},        32'(bus.psel),        32'h0);
        chk({tag, "_penable"},     32'(bus.penable),     32'h0);
        chk({tag, "_paddr"},       bus.paddr,            32'h0);
        chk({tag, "_pwrite"},      32'(bus.pwrite),      32'h0);
        chk({tag, "_pwdata"},      bus.pwdata,           32'h0);
        chk({tag, "_pprot"},       32'(bus.pprot),       32'h0);
        chk({tag, "_cmd_ready"},   32'(bus.cmd_ready),   32'h0);
        chk({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'h0);
        chk({tag, "_rsp_rdata"},   bus.rsp_rdata,        32'h0);
        chk({tag, "_rsp_err"},     32'(bus.rsp_err),     32'h0);
        chk({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'h0);
    endtask

    // Called at a falling edge; drives one command and waits (bounded) for acceptance.
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] prot, input string tag);
        int n;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_prot  = prot;
        n = 0;
        #1;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge pclk);
            #1;
            n++;
        end
        chk({tag, "_accept"}, 32'(bus.cmd_ready), 32'h1);
        @(posedge pclk);
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int   k;
        logic setup_ok;
        logic stable;
        cur_wait = v.waits;
        send_cmd(v.write, v.addr, v.wdata, v.prot, tag);
        k        = 1;
        setup_ok = 1'b1;
        stable   = 1'b1;
        while (!bus.rsp_valid && k < 60) begin
            if (k == 1) begin
                if ((bus.psel && !bus.penable && bus.paddr == v.addr && bus.pwrite == v.write &&
                     bus.pwdata == v.wdata && bus.pprot == v.prot) !== 1'b1) setup_ok = 1'b0;
            end else begin
                if ((bus.psel && bus.penable && bus.paddr == v.addr && bus.pwrite == v.write &&
                     bus.pwdata == v.wdata && bus.pprot == v.prot) !== 1'b1) stable = 1'b0;
            end
            @(negedge pclk);
            k++;
        end
        chk({tag, "_setup"},   32'(setup_ok),        32'h1);
        chk({tag, "_access"},  32'(stable),          32'h1);
        chk({tag, "_latency"}, 32'(k),               32'(v.exp_lat));
        chk({tag, "_rdata"},   bus.rsp_rdata,        v.exp_rdata);
        chk({tag, "_err"},     32'(bus.rsp_err),     32'(v.exp_err));
        chk({tag, "_timeout"}, 32'(bus.rsp_timeout), 32'(v.exp_to));
        chk({tag, "_psel_off"}, 32'({bus.psel, bus.penable}), 32'h0);
        @(negedge pclk);
        chk({tag, "_rsp_clr"}, 32'(bus.rsp_valid),   32'h0);
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b1, 32'd5,  32'hDEAD_BEEF, 3'd0, 0,     32'h0,         1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, 32'd5,  32'h0000_0000, 3'd0, 0,     32'hDEAD_BEEF, 1'b0, 1'b0, 3};
        vecs[2] = '{1'b0, 32'd17, 32'h0000_0000, 3'd0, 0,     32'h0,         1'b1, 1'b0, 3};
        vecs[3] = '{1'b1, 32'd3,  32'h1234_5678, 3'd2, 4,     32'h0,         1'b0, 1'b0, 7};
        vecs[4] = '{1'b0, 32'd3,  32'hCAFE_0000, 3'd0, 4,     32'h1234_5678, 1'b0, 1'b0, 7};
        vecs[5] = '{1'b0, 32'd7,  32'h0000_0000, 3'd0, NEVER, 32'h0,         1'b1, 1'b1, 19};
        vecs[6] = '{1'b0, 32'd5,  32'h0000_0000, 3'd0, 1,     32'hDEAD_BEEF, 1'b0, 1'b0, 4};
        vecs[7] = '{1'b1, 32'd20, 32'hAAAA_5555, 3'd0, 0,     32'h0,         1'b1, 1'b0, 3};
        vecs[8] = '{1'b0, 32'd3,  32'h0000_0000, 3'd5, 0,     32'h1234_5678, 1'b0, 1'b0, 3};
        vecs[9] = '{1'b0, 32'd5,  32'h0000_0000, 3'd0, 16,    32'hDEAD_BEEF, 1'b0, 1'b0, 19};

        preset        = 1'b1;
        mem_clr       = 1'b1;
        cur_wait      = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_prot  = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check_all_zero("reset");
        preset  = 1'b0;
        mem_clr = 1'b0;
        @(negedge pclk);

        for (int i = 0; i < NVEC; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while the slave stalls in ACCESS.
        cur_wait = NEVER;
        send_cmd(1'b0, 32'd7, 32'h0, 3'd0, "rstmid");
        @(negedge pclk);
        chk("rstmid_in_access", 32'({bus.psel, bus.penable}), 32'h3);
        preset = 1'b1;
        @(negedge pclk);
        check_all_zero("rstmid");
        preset   = 1'b0;
        cur_wait = 0;
        repeat (3) @(negedge pclk);
        chk("rstmid_no_rsp", 32'({bus.rsp_valid, bus.psel}), 32'h0);
        do_txn(vecs[1], "after_rst");

        // Held response blocks a pending command until it is consumed.
        bus.rsp_ready = 1'b0;
        cur_wait      = 0;
        send_cmd(1'b0, 32'd5, 32'h0, 3'd0, "bp_first");
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge pclk);
            n++;
        end
        chk("bp_first_rsp", 32'(bus.rsp_valid), 32'h1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'd3;
        bus.cmd_wdata = 32'h0;
        bus.cmd_prot  = 3'd0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_hold%0d_cmd_ready", c), 32'(bus.cmd_ready), 32'h0);
            chk($sformatf("bp_hold%0d_psel", c),      32'(bus.psel),      32'h0);
            chk($sformatf("bp_hold%0d_rsp", c),       bus.rsp_rdata,      32'hDEAD_BEEF);
            @(negedge pclk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        @(posedge pclk);
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        chk("bp_release_rsp_clr", 32'(bus.rsp_valid), 32'h0);
        chk("bp_second_setup", 32'({bus.psel, bus.penable}), 32'h2);
        chk("bp_second_addr", bus.paddr, 32'd3);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge pclk);
            n++;
        end
        chk("bp_second_rdata", bus.rsp_rdata, 32'h1234_5678);
        @(negedge pclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
